// File: rtl/g16_mul_rr_arbiter.sv
// g16_mul_rr_arbiter: one GF(2^4) normal-basis multiplier (basis alpha^8, alpha^2)
// shared round-robin among NREQ requesters. One accept per cycle, product
// registered once and returned with the winning requester index.
// Optional feature macro: G16_ARB_LOCK_EN (adds in_lock, sticky grant bursts).

// Combinational GF(2^4) multiplier, built as GF((2^2)^2) with both levels in
// normal basis. Upper nibble/bit pair is the coefficient of the conjugate root.
module g16_mul (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] z
);

  function automatic logic [1:0] g4_mul(input logic [1:0] p, input logic [1:0] q);
    logic e;
    e = (p[1] ^ p[0]) & (q[1] ^ q[0]);
    return {(p[1] & q[1]) ^ e, (p[0] & q[0]) ^ e};
  endfunction

  // Multiply by the GF(4) constant N that defines the quadratic extension.
  function automatic logic [1:0] g4_scl_n(input logic [1:0] p);
    return {p[0], p[1] ^ p[0]};
  endfunction

  logic [1:0] e_mul;
  logic [1:0] e_scl;
  logic [1:0] p_hi;
  logic [1:0] q_lo;

  // Shared cross term feeds both halves of the product.
  always_comb begin
    e_mul = g4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]);
    e_scl = g4_scl_n(e_mul);
    p_hi  = g4_mul(x[3:2], y[3:2]);
    q_lo  = g4_mul(x[1:0], y[1:0]);
    z     = {p_hi ^ e_scl, q_lo ^ e_scl};
  end

endmodule

module g16_mul_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   in_valid,
  output logic [NREQ-1:0]   in_ready,
  input  logic [4*NREQ-1:0] in_x,
  input  logic [4*NREQ-1:0] in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_z,
  output logic [IDW-1:0]    out_id
`ifdef G16_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]   in_lock
`endif
);

  logic           out_valid_q, out_valid_d;
  logic [3:0]     out_z_q,     out_z_d;
  logic [IDW-1:0] out_id_q,    out_id_d;
  logic [IDW-1:0] ptr_q,       ptr_d;
`ifdef G16_ARB_LOCK_EN
  logic [IDW-1:0] last_q,      last_d;
  logic           last_vld_q,  last_vld_d;
`endif

  logic           any_valid;
  logic           can_accept;
  logic           accept;
  logic           lock_hold;
  logic [IDW-1:0] grant;
  logic [3:0]     mul_x;
  logic [3:0]     mul_y;
  logic [3:0]     mul_z;

  // Grant selection: first valid index at or after ptr, with explicit wrap.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    logic           found;
    idx       = 0;
    idx_w     = '0;
    found     = 1'b0;
    grant     = '0;
    lock_hold = 1'b0;
    any_valid = |in_valid;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = idx[IDW-1:0];
      if (!found && in_valid[idx_w]) begin
        found = 1'b1;
        grant = idx_w;
      end
    end
`ifdef G16_ARB_LOCK_EN
    // A locked requester keeps the grant for as long as it stays valid.
    lock_hold = last_vld_q && in_lock[last_q] && in_valid[last_q];
    if (lock_hold) grant = last_q;
`endif
    can_accept = !out_valid_q || out_ready;
    accept     = can_accept && any_valid && !rst;
    in_ready   = '0;
    in_ready[grant] = accept;
  end

  // Operand mux into the single multiplier.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        mul_x = in_x[4*i +: 4];
        mul_y = in_y[4*i +: 4];
      end
    end
  end

  g16_mul u_g16_mul (
    .x (mul_x),
    .y (mul_y),
    .z (mul_z)
  );

  // Output stage and pointer next-state: accept refills, drain clears valid.
  always_comb begin
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
`ifdef G16_ARB_LOCK_EN
    last_d      = last_q;
    last_vld_d  = last_vld_q;
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      out_z_d     = mul_z;
      out_id_d    = grant;
      if (!lock_hold) begin
        ptr_d = (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
      end
`ifdef G16_ARB_LOCK_EN
      last_d     = grant;
      last_vld_d = 1'b1;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
`ifdef G16_ARB_LOCK_EN
      last_q      <= '0;
      last_vld_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
`ifdef G16_ARB_LOCK_EN
      last_q      <= last_d;
      last_vld_q  <= last_vld_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_id    = out_id_q;

endmodule
